param_sync_counter: RTL

Parametrised synchronous binary counter, the next generation of the fixed 3-bit up-counter. Width, modulo and end-of-range behaviour are set by parameters. Direction, enable and optional parallel load are run-time controls. A combinational terminal-count output allows cascading, and a registered wrap pulse serves event logic. It sits in the same designs as a timebase, divider or event counter.

---
 rtl/counter_pkg.sv | 38 +++
 rtl/counter_next.sv | 62 ++++++
 rtl/param_sync_counter.sv | 61 ++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared counter definitions: direction constants, parameter-check helper and
// the width-agnostic next-count rule reused by counter variants.
// Pure package, no state; no timing or flow control of its own.
package counter_pkg;

  localparam logic COUNT_UP   = 1'b1;
  localparam logic COUNT_DOWN = 1'b0;

  // Bits needed to hold values 0..value-1; used for elaboration checks.
  function automatic int clog2(input longint unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Next value of an enabled counter, computed one bit wider than any legal
  // counter so that a full-range modulo (last = 2^WIDTH-1) needs no special case.
  // Reaching an end wraps to the other end, or holds when sat is set.
  function automatic logic [32:0] next_count(input logic [32:0] cur,
                                             input logic [32:0] last,
                                             input logic        up,
                                             input logic        sat);
    logic [32:0] nxt;
    nxt = cur;
    if (up == COUNT_UP) begin
      if (cur < last) nxt = cur + 33'd1;
      else if (!sat)  nxt = '0;
    end else begin
      if (cur != '0)  nxt = cur - 33'd1;
      else if (!sat)  nxt = last;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Next-state logic for param_sync_counter: next count, wrap flag and terminal count.
// Latency: purely combinational, zero cycles.
// Backpressure: none; enable low simply holds the count. Load honoured only with COUNTER_LOAD_EN.
module counter_next
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] next_count_o,
  output logic             wrap_next_o,
  output logic             tc_o
);

  // Last count value, one bit wider than the counter so MODULO=2^WIDTH fits.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULO - 64'd1);

  logic [WIDTH:0] count_ext;
  logic [32:0]    step_val;
  logic           at_last;
  logic           at_zero;
  logic           unused_step_hi;

  assign count_ext = {1'b0, count_i};
  assign at_last   = (count_ext == LAST);
  assign at_zero   = (count_i == '0);
  assign step_val  = next_count(33'(count_ext), 33'(LAST), up_down_i, SATURATE);

  // Bits above the counter width are always zero for a legal MODULO.
  assign unused_step_hi = ^step_val[32:WIDTH];

  // Terminal count is the enabled end-of-range condition, used for cascading.
  assign tc_o = enable_i && (((up_down_i == COUNT_UP) && at_last) ||
                             ((up_down_i == COUNT_DOWN) && at_zero));

`ifndef COUNTER_LOAD_EN
  logic unused_load;
  assign unused_load = load_i ^ (^load_value_i);
`endif

  // Select load (clamped into range), an enabled step, or hold, in that priority.
  always_comb begin
    next_count_o = count_i;
    wrap_next_o  = 1'b0;
`ifdef COUNTER_LOAD_EN
    if (load_i) begin
      next_count_o = ({1'b0, load_value_i} > LAST) ? LAST[WIDTH-1:0] : load_value_i;
    end else
`endif
    if (enable_i) begin
      next_count_o = step_val[WIDTH-1:0];
      wrap_next_o  = tc_o && !SATURATE;
    end
  end

endmodule

// File: rtl/param_sync_counter.sv
// Parametrised up/down modulo counter with terminal count and wrap pulse; load needs COUNTER_LOAD_EN.
// Latency: count and wrap update one edge after enable/load are sampled; tc is combinational.
// Backpressure: none; enable low holds the count, load overrides enable.
module param_sync_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_sync_counter: WIDTH must be in 2..32");
  end
  if (MODULO < 2 || clog2(MODULO) > WIDTH) begin : g_bad_modulo
    $error("param_sync_counter: MODULO must be in 2..2^WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  counter_next #(
    .WIDTH    (WIDTH),
    .MODULO   (MODULO),
    .SATURATE (SATURATE)
  ) u_next (
    .count_i      (count_q),
    .enable_i     (enable),
    .up_down_i    (up_down),
    .load_i       (load),
    .load_value_i (load_value),
    .next_count_o (count_d),
    .wrap_next_o  (wrap_d),
    .tc_o         (tc)
  );

  // Count and wrap registers; reset clears both without waiting for an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
